// File: rtl/blink_monitor.sv
// blink_monitor: receive-side monitor for a blink line.
// Recovers whether the line is blinking, measures the half-period in clock cycles,
// and flags out-of-tolerance half-periods (glitch) and loss of blinking (timeout).
// Optional build macro: BLINK_MON_COUNT_EN adds a 16-bit count of locked edges;
// without it edge_count is tied to zero and the port list is unchanged.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no blinking seen; the first edge starts a partial, discarded run
// S_SYNC1 | first full run being measured
// S_SYNC2 | reference run held in r_ref; waiting for a matching run to lock
// S_LOCK  | locked; each run compared with half_period within TOL

module blink_monitor #(
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 64,
  parameter int TOL       = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] half_period,
  output logic                 glitch,
  output logic                 level,
  output logic [15:0]          edge_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC1 = 2'd1,
    S_SYNC2 = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH:0]   LP_TOL     = (CNT_WIDTH+1)'(TOL);

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_in_q;
  logic [CNT_WIDTH-1:0] r_run_cnt;
  logic [CNT_WIDTH-1:0] r_ref;
  logic [CNT_WIDTH-1:0] r_half_period;
  logic                 r_active;
  logic                 r_glitch;

  logic                 w_edge;
  logic                 w_timeout;
  logic [CNT_WIDTH-1:0] w_run_cnt_nxt;
  logic [CNT_WIDTH:0]   w_diff_ref;
  logic [CNT_WIDTH:0]   w_diff_half;
  logic                 w_ref_ok;
  logic                 w_half_ok;

  logic                 w_load_ref;
  logic                 w_load_half;
  logic                 w_active_nxt;
  logic                 w_glitch_nxt;
  logic                 w_accept_lock;

  // Unsigned distance computed one bit wider so it can never wrap.
  function automatic logic [CNT_WIDTH:0] f_absdiff(
    input logic [CNT_WIDTH-1:0] a,
    input logic [CNT_WIDTH-1:0] b
  );
    logic [CNT_WIDTH:0] w_a;
    logic [CNT_WIDTH:0] w_b;
    w_a = {1'b0, a};
    w_b = {1'b0, b};
    return (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  endfunction

  // r_run_cnt still holds the length of the run that the current edge terminates.
  assign w_edge      = (in != r_in_q);
  assign w_timeout   = !w_edge && (r_run_cnt == LP_TIMEOUT);
  assign w_diff_ref  = f_absdiff(r_run_cnt, r_ref);
  assign w_diff_half = f_absdiff(r_run_cnt, r_half_period);
  assign w_ref_ok    = (w_diff_ref <= LP_TOL);
  assign w_half_ok   = (w_diff_half <= LP_TOL);

  // Run counter restarts at 1 on an edge and saturates so long idle periods never wrap.
  always_comb begin
    w_run_cnt_nxt = r_run_cnt;
    if (w_edge) begin
      w_run_cnt_nxt = LP_ONE;
    end else if (r_run_cnt != LP_CNT_MAX) begin
      w_run_cnt_nxt = r_run_cnt + LP_ONE;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and register-update decisions; an edge always wins over a timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_ref    = 1'b0;
    w_load_half   = 1'b0;
    w_active_nxt  = r_active;
    w_glitch_nxt  = 1'b0;
    w_accept_lock = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_active_nxt = 1'b0;
        if (w_edge) begin
          w_state_nxt = S_SYNC1;
        end
      end
      S_SYNC1: begin
        if (w_edge) begin
          w_state_nxt = S_SYNC2;
          w_load_ref  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      end
      S_SYNC2: begin
        if (w_edge) begin
          if (w_ref_ok) begin
            w_state_nxt   = S_LOCK;
            w_load_half   = 1'b1;
            w_active_nxt  = 1'b1;
            w_accept_lock = 1'b1;
          end else begin
            w_load_ref = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      end
      S_LOCK: begin
        if (w_edge) begin
          if (w_half_ok) begin
            w_load_half   = 1'b1;
            w_accept_lock = 1'b1;
          end else begin
            // The bad run becomes the new reference, so relock needs two more matching runs.
            w_state_nxt  = S_SYNC2;
            w_glitch_nxt = 1'b1;
            w_active_nxt = 1'b0;
            w_load_ref   = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers; half_period only moves on an accepted run and holds while unlocked.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_q        <= 1'b0;
      r_run_cnt     <= '0;
      r_ref         <= '0;
      r_half_period <= '0;
      r_active      <= 1'b0;
      r_glitch      <= 1'b0;
    end else begin
      r_in_q    <= in;
      r_run_cnt <= w_run_cnt_nxt;
      if (w_load_ref) begin
        r_ref <= r_run_cnt;
      end
      if (w_load_half) begin
        r_half_period <= r_run_cnt;
      end
      r_active <= w_active_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

`ifdef BLINK_MON_COUNT_EN
  logic [15:0] r_edge_count;

  // Count of edges accepted while locked, including the locking edge; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_edge_count <= 16'h0000;
    end else if (w_accept_lock) begin
      r_edge_count <= r_edge_count + 16'd1;
    end
  end

  assign edge_count = r_edge_count;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept_lock;
  assign edge_count      = 16'h0000;
`endif

  assign active      = r_active;
  assign half_period = r_half_period;
  assign glitch      = r_glitch;
  assign level       = r_in_q;

endmodule

// File: tb/tb_blink_monitor.sv
module tb_blink_monitor;

  localparam int CW = 8;
`ifdef BLINK_MON_COUNT_EN
  localparam logic [15:0] EC_AFTER_13 = 16'd11;
`else
  localparam logic [15:0] EC_AFTER_13 = 16'd0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_r  = 1'b0;
  logic          active;
  logic [CW-1:0] half_period;
  logic          glitch;
  logic          level;
  logic [15:0]   edge_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          act;
    logic [CW-1:0] half;
    logic          gl;
    logic          lvl;
    logic [15:0]   ec;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_ec = 16'd0;

  blink_monitor #(.CNT_WIDTH(CW), .TIMEOUT(64), .TOL(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in_r),
    .active      (active),
    .half_period (half_period),
    .glitch      (glitch),
    .level       (level),
    .edge_count  (edge_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // acc marks an edge the monitor should accept while locked (counted when the feature is built).
  task automatic push_exp(input logic a, input logic [CW-1:0] h, input logic g, input logic acc);
    exp_t e;
`ifdef BLINK_MON_COUNT_EN
    if (acc) exp_ec = exp_ec + 16'd1;
`else
    if (acc) exp_ec = 16'd0;
`endif
    e.act  = a;
    e.half = h;
    e.gl   = g;
    e.lvl  = in_r;
    e.ec   = exp_ec;
    exp_q.push_back(e);
  endtask

  task automatic edge_tick(input logic a, input logic [CW-1:0] h, input logic g);
    in_r = ~in_r;
    push_exp(a, h, g, a);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    in_r  = 1'b0;
    tick();
    reset  = 1'b0;
    exp_ec = 16'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    in_r   = 1'b0;
    exp_ec = 16'd0;
    push_exp(1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if ({active, half_period, glitch, level, edge_count} !== {e.act, e.half, e.gl, e.lvl, e.ec}) begin
      n_fail++;
      $display("FAIL reset: got act=%b half=%0d gl=%b lvl=%b ec=%0d want act=%b half=%0d gl=%b lvl=%b ec=%0d",
               active, half_period, glitch, level, edge_count, e.act, e.half, e.gl, e.lvl, e.ec);
    end
  endtask

  task automatic test_lock();
    exp_t e;
    for (int k = 0; k < 23; k++) begin
      edge_tick(k >= 2, (k >= 2) ? 8'd5 : 8'd0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, glitch, level, edge_count} !== {e.act, e.half, e.gl, e.lvl, e.ec}) begin
        n_fail++;
        $display("FAIL lock edge %0d: got act=%b half=%0d gl=%b lvl=%b ec=%0d want act=%b half=%0d gl=%b lvl=%b ec=%0d",
                 k, active, half_period, glitch, level, edge_count, e.act, e.half, e.gl, e.lvl, e.ec);
      end
      hold(4);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   holds[6]        = '{2, 1, 4, 5, 5, 5};
    logic acts[6]         = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic gls[6]          = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic is_edge[6]      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    // Runs: 5 (closing) then a 2-cycle run, then 5,5,5; index 2 is the cycle right after the glitch.
    for (int k = 0; k < 6; k++) begin
      if (is_edge[k]) begin
        edge_tick(acts[k], 8'd5, gls[k]);
      end else begin
        push_exp(acts[k], 8'd5, gls[k], 1'b0);
        tick();
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, glitch, level, edge_count} !== {e.act, e.half, e.gl, e.lvl, e.ec}) begin
        n_fail++;
        $display("FAIL glitch step %0d: got act=%b half=%0d gl=%b lvl=%b ec=%0d want act=%b half=%0d gl=%b lvl=%b ec=%0d",
                 k, active, half_period, glitch, level, edge_count, e.act, e.half, e.gl, e.lvl, e.ec);
      end
      hold(holds[k] - 1);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic saw_gl = 1'b0;
    edge_tick(1'b1, 8'd5, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({active, half_period, glitch, edge_count} !== {e.act, e.half, e.gl, e.ec}) begin
      n_fail++;
      $display("FAIL timeout last edge: got act=%b half=%0d gl=%b ec=%0d want act=%b half=%0d gl=%b ec=%0d",
               active, half_period, glitch, edge_count, e.act, e.half, e.gl, e.ec);
    end
    push_exp(1'b1, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) begin
      tick();
      if (glitch) saw_gl = 1'b1;
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({active, half_period, glitch, edge_count} !== {e.act, e.half, e.gl, e.ec}) begin
      n_fail++;
      $display("FAIL timeout at 63: got act=%b half=%0d gl=%b ec=%0d want act=%b half=%0d gl=%b ec=%0d",
               active, half_period, glitch, edge_count, e.act, e.half, e.gl, e.ec);
    end
    push_exp(1'b0, 8'd5, 1'b0, 1'b0);
    tick();
    if (glitch) saw_gl = 1'b1;
    e = exp_q.pop_front();
    n_checks++;
    if ({active, half_period, glitch, edge_count} !== {e.act, e.half, e.gl, e.ec}) begin
      n_fail++;
      $display("FAIL timeout at 64: got act=%b half=%0d gl=%b ec=%0d want act=%b half=%0d gl=%b ec=%0d",
               active, half_period, glitch, edge_count, e.act, e.half, e.gl, e.ec);
    end
    n_checks++;
    if (saw_gl !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout glitch: got pulse=%b want pulse=0", saw_gl);
    end
    hold(10);
  endtask

  task automatic test_alt();
    exp_t          e;
    int            holds[9] = '{5, 6, 5, 6, 5, 6, 5, 8, 5};
    logic          acts[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [CW-1:0] halfs[9] = '{8'd5, 8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd5};
    logic          gls[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 9; k++) begin
      edge_tick(acts[k], halfs[k], gls[k]);
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, glitch, level, edge_count} !== {e.act, e.half, e.gl, e.lvl, e.ec}) begin
        n_fail++;
        $display("FAIL alt edge %0d: got act=%b half=%0d gl=%b lvl=%b ec=%0d want act=%b half=%0d gl=%b lvl=%b ec=%0d",
                 k, active, half_period, glitch, level, edge_count, e.act, e.half, e.gl, e.lvl, e.ec);
      end
      if (k == 8) begin
        push_exp(1'b0, 8'd5, 1'b0, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({active, glitch} !== {e.act, e.gl}) begin
          n_fail++;
          $display("FAIL alt after glitch: got act=%b gl=%b want act=%b gl=%b", active, glitch, e.act, e.gl);
        end
        hold(holds[k] - 2);
      end else begin
        hold(holds[k] - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      edge_tick(k == 2, (k == 2) ? 8'd5 : 8'd0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, glitch, edge_count} !== {e.act, e.half, e.gl, e.ec}) begin
        n_fail++;
        $display("FAIL rstmid lock %0d: got act=%b half=%0d gl=%b ec=%0d want act=%b half=%0d gl=%b ec=%0d",
                 k, active, half_period, glitch, edge_count, e.act, e.half, e.gl, e.ec);
      end
      hold(4);
    end
    edge_tick(1'b1, 8'd5, 1'b0);
    void'(exp_q.pop_front());
    hold(2);
    reset  = 1'b1;
    in_r   = 1'b0;
    exp_ec = 16'd0;
    push_exp(1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if ({active, half_period, glitch, level, edge_count} !== {e.act, e.half, e.gl, e.lvl, e.ec}) begin
      n_fail++;
      $display("FAIL rstmid reset: got act=%b half=%0d gl=%b lvl=%b ec=%0d want act=%b half=%0d gl=%b lvl=%b ec=%0d",
               active, half_period, glitch, level, edge_count, e.act, e.half, e.gl, e.lvl, e.ec);
    end
    for (int k = 0; k < 3; k++) begin
      edge_tick(k == 2, (k == 2) ? 8'd5 : 8'd0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, glitch, edge_count} !== {e.act, e.half, e.gl, e.ec}) begin
        n_fail++;
        $display("FAIL rstmid relock %0d: got act=%b half=%0d gl=%b ec=%0d want act=%b half=%0d gl=%b ec=%0d",
                 k, active, half_period, glitch, edge_count, e.act, e.half, e.gl, e.ec);
      end
      hold(4);
    end
  endtask

  task automatic test_edge_count();
    exp_t e;
    pulse_reset();
    for (int k = 0; k < 13; k++) begin
      edge_tick(k >= 2, (k >= 2) ? 8'd5 : 8'd0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({active, half_period, edge_count} !== {e.act, e.half, e.ec}) begin
        n_fail++;
        $display("FAIL count edge %0d: got act=%b half=%0d ec=%0d want act=%b half=%0d ec=%0d",
                 k, active, half_period, edge_count, e.act, e.half, e.ec);
      end
      hold(4);
    end
    n_checks++;
    if (edge_count !== EC_AFTER_13) begin
      n_fail++;
      $display("FAIL count final: got ec=%0d want ec=%0d", edge_count, EC_AFTER_13);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_glitch();
    test_timeout();
    test_alt();
    test_reset_mid();
    test_edge_count();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
